// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - shared types, limits and SR decode for the flag arbiter
package sr_flag_pkg;

  localparam int CONFLICT_W = 8;
  localparam logic [CONFLICT_W-1:0] CONFLICT_MAX = 8'd255;

  typedef enum logic [1:0] {HOLD, SET, CLR, BOTH} flag_op_t;

  function automatic flag_op_t decode_op(input logic s, input logic c);
    case ({s, c})
      2'b10:   return SET;
      2'b01:   return CLR;
      2'b11:   return BOTH;
      default: return HOLD;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = '0;
    // Walk last+1 .. last+N; offset N wraps back to last itself.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin SR flag bank; SR_FLAG_TOGGLE_EN makes S=R=1 toggle
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NFLAG-1:0] set_mask,
  input  logic [NREQ*NFLAG-1:0] clr_mask,
  output logic [NREQ-1:0]       gnt,
  output logic [NFLAG-1:0]      flags,
  output logic [NFLAG-1:0]      flags_n,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]    last;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  winner;
  logic [IW-1:0]    winner_idx;
  logic             any_win;
  logic [NFLAG-1:0] win_set;
  logic [NFLAG-1:0] win_clr;
  logic [NFLAG-1:0] next_q;
  logic             any_both;

  // A requester still showing its grant is skipped while it drops req.
  assign eligible = req & ~gnt;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .eligible   (eligible),
    .last       (last),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  assign any_win  = |winner;
  assign win_set  = set_mask[winner_idx*NFLAG +: NFLAG];
  assign win_clr  = clr_mask[winner_idx*NFLAG +: NFLAG];
  assign any_both = |(win_set & win_clr);

  for (genvar b = 0; b < NFLAG; b++) begin : g_bit
    logic q_nxt;
    always_comb begin
      q_nxt = flags[b];
      case (decode_op(win_set[b], win_clr[b]))
        SET:  q_nxt = 1'b1;
        CLR:  q_nxt = 1'b0;
`ifdef SR_FLAG_TOGGLE_EN
        BOTH: q_nxt = ~flags[b];
`else
        BOTH: q_nxt = flags[b];
`endif
        HOLD: q_nxt = flags[b];
      endcase
    end
    assign next_q[b] = q_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= '0;
      flags        <= '0;
      flags_n      <= '1;
      conflict_cnt <= '0;
      last         <= IW'(NREQ - 1);
    end else begin
      gnt <= winner;
      if (any_win) begin
        last    <= winner_idx;
        flags   <= next_q;
        flags_n <= ~next_q;
        if (any_both && conflict_cnt != CONFLICT_MAX)
          conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*NFLAG-1:0] set_mask;
  logic [NREQ*NFLAG-1:0] clr_mask;
  logic [NREQ-1:0]       gnt;
  logic [NFLAG-1:0]      flags;
  logic [NFLAG-1:0]      flags_n;
  logic [7:0]            conflict_cnt;

  int total = 0;
  int bad   = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .set_mask     (set_mask),
    .clr_mask     (clr_mask),
    .gnt          (gnt),
    .flags        (flags),
    .flags_n      (flags_n),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; set_mask = '0; clr_mask = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", flags); end
    total++; if (flags_n !== 8'hFF) begin bad++; $display("FAIL reset_flags_n got=%h exp=ff", flags_n); end
    total++; if (conflict_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
  endtask

  task automatic test_single();
    req = 4'b0001; set_mask[0 +: 8] = 8'hA5;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++; if (flags !== 8'hA5) begin bad++; $display("FAIL single_flags got=%h exp=a5", flags); end
    total++; if (flags_n !== 8'h5A) begin bad++; $display("FAIL single_flags_n got=%h exp=5a", flags_n); end
    req = '0; set_mask = '0;
    step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_drop got=%b exp=0000", gnt); end
    total++; if (flags !== 8'hA5) begin bad++; $display("FAIL single_flags_keep got=%h exp=a5", flags); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  exp_g;
    logic [NREQ-1:0]  prev_g;
    logic [NFLAG-1:0] exp_f;
    logic [NFLAG-1:0] seed;
    int cnt [NREQ];
    do_reset();
    seed = 8'h11;
    for (int i = 0; i < NREQ; i++) begin
      set_mask[i*NFLAG +: NFLAG] = seed << i;
      cnt[i] = 0;
    end
    req    = 4'b1111;
    exp_f  = 8'h00;
    prev_g = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_g = 4'b0001 << (k % NREQ);
      exp_f = exp_f | (seed << (k % NREQ));
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, exp_g); end
      total++; if (flags !== exp_f) begin bad++; $display("FAIL rr_flags k=%0d got=%h exp=%h", k, flags, exp_f); end
      total++; if ((gnt & prev_g) !== 4'b0000) begin bad++; $display("FAIL rr_repeat k=%0d got=%b prev=%b", k, gnt, prev_g); end
      for (int i = 0; i < NREQ; i++) if (gnt[i]) cnt[i]++;
      prev_g = gnt;
    end
    for (int i = 0; i < NREQ; i++) begin
      total++; if (cnt[i] != 2) begin bad++; $display("FAIL rr_count req=%0d got=%0d exp=2", i, cnt[i]); end
    end
    req = '0; set_mask = '0;
    step();
  endtask

  task automatic test_clear_hold();
    req = 4'b0100; set_mask[2*8 +: 8] = 8'h00; clr_mask[2*8 +: 8] = 8'h0F;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL clr_gnt got=%b exp=0100", gnt); end
    total++; if (flags !== 8'hF0) begin bad++; $display("FAIL clr_flags got=%h exp=f0", flags); end
    total++; if (flags_n !== 8'h0F) begin bad++; $display("FAIL clr_flags_n got=%h exp=0f", flags_n); end
    req = '0; clr_mask = '0;
    step();
    req = 4'b0100;
    step();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL hold_gnt got=%b exp=0100", gnt); end
    total++; if (flags !== 8'hF0) begin bad++; $display("FAIL hold_flags got=%h exp=f0", flags); end
    req = '0;
    step();
  endtask

  task automatic test_conflict();
    logic [7:0] exp_first;
`ifdef SR_FLAG_TOGGLE_EN
    exp_first = 8'h02;
`else
    exp_first = 8'h01;
`endif
    do_reset();
    req = 4'b0001; set_mask[0 +: 8] = 8'h01;
    step();
    req = '0; set_mask = '0;
    step();
    total++; if (flags !== 8'h01) begin bad++; $display("FAIL cf_pre_flags got=%h exp=01", flags); end
    set_mask[1*8 +: 8] = 8'h03; clr_mask[1*8 +: 8] = 8'h03;
    req = 4'b0010;
    step();
    req = '0;
    total++; if (flags !== exp_first) begin bad++; $display("FAIL cf_flags got=%h exp=%h", flags, exp_first); end
    total++; if (conflict_cnt !== 8'd1) begin bad++; $display("FAIL cf_cnt got=%0d exp=1", conflict_cnt); end
    step();
    for (int n = 2; n <= 300; n++) begin
      req = 4'b0010;
      step();
      req = '0;
      step();
      if (n == 254) begin
        total++; if (conflict_cnt !== 8'd254) begin bad++; $display("FAIL cf_cnt254 got=%0d exp=254", conflict_cnt); end
      end
      if (n == 255) begin
        total++; if (conflict_cnt !== 8'd255) begin bad++; $display("FAIL cf_cnt255 got=%0d exp=255", conflict_cnt); end
      end
    end
    total++; if (conflict_cnt !== 8'd255) begin bad++; $display("FAIL cf_sat got=%0d exp=255", conflict_cnt); end
    total++; if (flags !== 8'h01) begin bad++; $display("FAIL cf_flags300 got=%h exp=01", flags); end
    set_mask = '0; clr_mask = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_mask[1*8 +: 8] = 8'hF0; set_mask[2*8 +: 8] = 8'h0F;
    req = 4'b0110;
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_gnt got=%b exp=0010", gnt); end
    total++; if (flags !== 8'hF0) begin bad++; $display("FAIL mid_flags got=%h exp=f0", flags); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_rst_gnt got=%b exp=0000", gnt); end
    total++; if (flags !== 8'h00) begin bad++; $display("FAIL mid_rst_flags got=%h exp=00", flags); end
    total++; if (flags_n !== 8'hFF) begin bad++; $display("FAIL mid_rst_flags_n got=%h exp=ff", flags_n); end
    total++; if (conflict_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", conflict_cnt); end
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_regnt got=%b exp=0010", gnt); end
    total++; if (flags !== 8'hF0) begin bad++; $display("FAIL mid_reflags got=%h exp=f0", flags); end
    req = '0; set_mask = '0;
    step();
  endtask

  initial begin
    rst = 1'b1; req = '0; set_mask = '0; clr_mask = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_clear_hold();
    test_conflict();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
